// File: rtl/mem_arb_pkg.sv
// Shared encodings for the instruction/data memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

  // Width of the latency counter and the starvation streak counter (both max 7).
  localparam int CNT_W = 3;

  // Instruction fetches are always full-word reads.
  localparam logic [2:0] FETCH_FUNCT3 = 3'b010;

endpackage

// File: rtl/mem_arbiter_timer.sv
// Loadable down-counter that measures the memory access latency.
module latency_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: load wins, otherwise count down and stop at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (fetch / data) arbiter in front of a single fixed-latency memory port.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int LATENCY    = 2,
  parameter int MAX_STREAK = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_valid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [2:0]        d_funct3,
  output logic              d_gnt,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic [2:0]        m_funct3,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              busy
);

  localparam logic [CNT_W-1:0] LOAD_VAL   = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] STREAK_MAX = CNT_W'(MAX_STREAK);

  state_e             state_q, state_d;
  owner_e             owner_q, owner_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [2:0]         funct3_q, funct3_d;
  logic [CNT_W-1:0]   streak_q, streak_d;
  logic               i_gnt_q, i_gnt_d, d_gnt_q, d_gnt_d;
  logic               i_valid_q, i_valid_d, d_valid_q, d_valid_d;
  logic [DATA_W-1:0]  i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic               tmr_load, tmr_en, tmr_zero;
  logic               pick_i, pick_d;
  logic               in_access;

  // Data normally wins; fetch wins when alone or once data has hogged the port MAX_STREAK times.
  assign pick_i = i_req && (!d_req || (streak_q == STREAK_MAX));
  assign pick_d = d_req && !pick_i;

  latency_timer #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (LOAD_VAL),
    .en       (tmr_en),
    .zero     (tmr_zero)
  );

  // Next-state, arbitration, streak tracking and response capture.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    funct3_d  = funct3_q;
    streak_d  = streak_q;
    i_gnt_d   = 1'b0;
    d_gnt_d   = 1'b0;
    i_valid_d = 1'b0;
    d_valid_d = 1'b0;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    tmr_load  = 1'b0;
    tmr_en    = 1'b0;
    case (state_q)
      IDLE, RESP: begin
        state_d = IDLE;
        if (pick_i) begin
          state_d  = ACCESS;
          tmr_load = 1'b1;
          owner_d  = OWN_I;
          we_d     = 1'b0;
          addr_d   = i_addr;
          wdata_d  = '0;
          funct3_d = FETCH_FUNCT3;
          i_gnt_d  = 1'b1;
        end else if (pick_d) begin
          state_d  = ACCESS;
          tmr_load = 1'b1;
          owner_d  = OWN_D;
          we_d     = d_we;
          addr_d   = d_addr;
          wdata_d  = d_wdata;
          funct3_d = d_funct3;
          d_gnt_d  = 1'b1;
        end
        if (pick_i || !i_req) begin
          streak_d = '0;
        end else if (pick_d && (streak_q != STREAK_MAX)) begin
          streak_d = streak_q + 1'b1;
        end
      end
      ACCESS: begin
        tmr_en = 1'b1;
        if (tmr_zero) begin
          state_d = RESP;
          if (owner_q == OWN_I) begin
            i_valid_d = 1'b1;
            i_rdata_d = we_q ? '0 : m_rdata;
          end else begin
            d_valid_d = 1'b1;
            d_rdata_d = we_q ? '0 : m_rdata;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= OWN_I;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      funct3_q  <= '0;
      streak_q  <= '0;
      i_gnt_q   <= 1'b0;
      d_gnt_q   <= 1'b0;
      i_valid_q <= 1'b0;
      d_valid_q <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      funct3_q  <= funct3_d;
      streak_q  <= streak_d;
      i_gnt_q   <= i_gnt_d;
      d_gnt_q   <= d_gnt_d;
      i_valid_q <= i_valid_d;
      d_valid_q <= d_valid_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign in_access = (state_q == ACCESS);
  assign busy      = (state_q != IDLE);
  assign m_en      = in_access;
  assign m_we      = in_access && we_q;
  assign m_addr    = in_access ? addr_q   : '0;
  assign m_wdata   = in_access ? wdata_q  : '0;
  assign m_funct3  = in_access ? funct3_q : '0;
  assign i_gnt     = i_gnt_q;
  assign d_gnt     = d_gnt_q;
  assign i_valid   = i_valid_q;
  assign d_valid   = d_valid_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (LATENCY=2 main instance, LATENCY=1 side instance).
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        i_req, i_gnt, i_valid;
  logic [7:0]  i_addr;
  logic [31:0] i_rdata;
  logic        d_req, d_we, d_gnt, d_valid;
  logic [7:0]  d_addr;
  logic [31:0] d_wdata, d_rdata;
  logic [2:0]  d_funct3;
  logic        m_en, m_we, busy;
  logic [7:0]  m_addr;
  logic [31:0] m_wdata, m_rdata;
  logic [2:0]  m_funct3;

  logic        x_i_req, x_i_gnt, x_i_valid;
  logic [7:0]  x_i_addr;
  logic [31:0] x_i_rdata;
  logic        x_d_req, x_d_gnt, x_d_valid;
  logic [7:0]  x_d_addr;
  logic [31:0] x_d_rdata;
  logic        x_m_en, x_m_we, x_busy;
  logic [7:0]  x_m_addr;
  logic [31:0] x_m_wdata, x_m_rdata;
  logic [2:0]  x_m_funct3;

  logic [31:0] mem [256];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(8), .DATA_W(32), .LATENCY(2), .MAX_STREAK(3)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_valid(i_valid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_funct3(d_funct3),
    .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_funct3(m_funct3),
    .m_rdata(m_rdata), .busy(busy)
  );

  mem_arbiter #(.ADDR_W(8), .DATA_W(32), .LATENCY(1), .MAX_STREAK(3)) dut1 (
    .clk(clk), .rst(rst),
    .i_req(x_i_req), .i_addr(x_i_addr), .i_gnt(x_i_gnt), .i_valid(x_i_valid), .i_rdata(x_i_rdata),
    .d_req(x_d_req), .d_we(1'b0), .d_addr(x_d_addr), .d_wdata(32'h0), .d_funct3(3'b010),
    .d_gnt(x_d_gnt), .d_valid(x_d_valid), .d_rdata(x_d_rdata),
    .m_en(x_m_en), .m_we(x_m_we), .m_addr(x_m_addr), .m_wdata(x_m_wdata), .m_funct3(x_m_funct3),
    .m_rdata(x_m_rdata), .busy(x_busy)
  );

  // Memory model: combinational read while enabled, write on the clock edge.
  assign m_rdata   = m_en   ? mem[m_addr]   : 32'h0;
  assign x_m_rdata = x_m_en ? mem[x_m_addr] : 32'h0;

  always @(posedge clk) begin
    if (m_en && m_we) mem[m_addr] <= m_wdata;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic ireq, input logic [7:0] iaddr, input logic dreq,
                               input logic dwe, input logic [7:0] daddr,
                               input logic [31:0] dwdata, input logic [2:0] dfunct3);
    i_req    = ireq;
    i_addr   = iaddr;
    d_req    = dreq;
    d_we     = dwe;
    d_addr   = daddr;
    d_wdata  = dwdata;
    d_funct3 = dfunct3;
  endtask

  // Collect n grants from the main instance; order bit is 1 for fetch, 0 for data.
  task automatic grantOrder(input int n, output logic [7:0] order, output int first_cyc,
                            output int last_cyc);
    int cyc;
    int cnt;
    cyc = 0;
    cnt = 0;
    order = '0;
    first_cyc = -1;
    last_cyc = -1;
    while (cnt < n && cyc < 60) begin
      step();
      cyc++;
      checkOutput("gnt_mutex", 32'(i_gnt & d_gnt), 32'h0);
      checkOutput("valid_mutex", 32'(i_valid & d_valid), 32'h0);
      if (i_gnt || d_gnt) begin
        order = {order[6:0], i_gnt};
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        cnt++;
      end
    end
    if (cnt < n) checkOutput("grant_timeout", 32'(cnt), 32'(n));
  endtask

  initial begin
    logic [7:0] order;
    int first_cyc, last_cyc, cyc, cnt;

    for (int a = 0; a < 256; a++) mem[a] = 32'hA500_0000 | 32'(a);
    mem[8'h04] = 32'h00A0_0093;
    mem[8'h10] = 32'h1234_5678;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0, 3'b000);
    x_i_req = 1'b0; x_i_addr = 8'h00; x_d_req = 1'b0; x_d_addr = 8'h00;

    $display("[TB] reset state");
    #1;
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_m_en", 32'(m_en), 32'h0);
    checkOutput("rst_i_gnt", 32'(i_gnt), 32'h0);
    checkOutput("rst_d_valid", 32'(d_valid), 32'h0);
    checkOutput("rst_d_rdata", d_rdata, 32'h0);
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] fetch read");
    rst = 1'b0;
    applyStimulus(1'b1, 8'h04, 1'b0, 1'b0, 8'h00, 32'h0, 3'b000);
    step();
    checkOutput("f_c1_i_gnt", 32'(i_gnt), 32'h1);
    checkOutput("f_c1_d_gnt", 32'(d_gnt), 32'h0);
    checkOutput("f_c1_m_en", 32'(m_en), 32'h1);
    checkOutput("f_c1_m_addr", 32'(m_addr), 32'h04);
    checkOutput("f_c1_m_we", 32'(m_we), 32'h0);
    checkOutput("f_c1_busy", 32'(busy), 32'h1);
    i_req = 1'b0;
    step();
    checkOutput("f_c2_i_gnt", 32'(i_gnt), 32'h0);
    checkOutput("f_c2_m_en", 32'(m_en), 32'h1);
    checkOutput("f_c2_i_valid", 32'(i_valid), 32'h0);
    step();
    checkOutput("f_c3_i_valid", 32'(i_valid), 32'h1);
    checkOutput("f_c3_i_rdata", i_rdata, 32'h00A0_0093);
    checkOutput("f_c3_m_en", 32'(m_en), 32'h0);
    checkOutput("f_c3_busy", 32'(busy), 32'h1);
    step();
    checkOutput("f_c4_busy", 32'(busy), 32'h0);
    checkOutput("f_c4_i_valid", 32'(i_valid), 32'h0);
    checkOutput("f_c4_i_rdata_hold", i_rdata, 32'h00A0_0093);

    $display("[TB] simultaneous requests");
    applyStimulus(1'b1, 8'h08, 1'b1, 1'b0, 8'h10, 32'h0, 3'b010);
    step();
    checkOutput("s_c1_d_gnt", 32'(d_gnt), 32'h1);
    checkOutput("s_c1_i_gnt", 32'(i_gnt), 32'h0);
    checkOutput("s_c1_m_addr", 32'(m_addr), 32'h10);
    d_req = 1'b0;
    step();
    step();
    checkOutput("s_c3_d_valid", 32'(d_valid), 32'h1);
    checkOutput("s_c3_d_rdata", d_rdata, 32'h1234_5678);
    checkOutput("s_c3_i_valid", 32'(i_valid), 32'h0);
    step();
    checkOutput("s_c4_i_gnt", 32'(i_gnt), 32'h1);
    checkOutput("s_c4_m_addr", 32'(m_addr), 32'h08);
    i_req = 1'b0;
    step();
    step();
    checkOutput("s_c6_i_valid", 32'(i_valid), 32'h1);
    checkOutput("s_c6_i_rdata", i_rdata, 32'hA500_0008);
    step();

    $display("[TB] fairness under continuous load");
    applyStimulus(1'b1, 8'h04, 1'b1, 1'b0, 8'h10, 32'h0, 3'b010);
    grantOrder(8, order, first_cyc, last_cyc);
    checkOutput("fair_order", 32'(order), 32'h11);
    checkOutput("fair_spacing", 32'(last_cyc - first_cyc), 32'd21);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0, 3'b000);
    repeat (3) step();
    checkOutput("fair_drain_busy", 32'(busy), 32'h0);

    $display("[TB] write then read back");
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 8'h20, 32'hDEAD_BEEF, 3'b010);
    step();
    checkOutput("w_c1_d_gnt", 32'(d_gnt), 32'h1);
    checkOutput("w_c1_m_we", 32'(m_we), 32'h1);
    checkOutput("w_c1_m_wdata", m_wdata, 32'hDEAD_BEEF);
    checkOutput("w_c1_m_funct3", 32'(m_funct3), 32'h2);
    d_req = 1'b0;
    step();
    checkOutput("w_c2_m_we", 32'(m_we), 32'h1);
    step();
    checkOutput("w_c3_d_valid", 32'(d_valid), 32'h1);
    checkOutput("w_c3_d_rdata", d_rdata, 32'h0);
    checkOutput("w_c3_m_we", 32'(m_we), 32'h0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 8'h20, 32'h0, 3'b010);
    step();
    checkOutput("r_c4_d_gnt", 32'(d_gnt), 32'h1);
    d_req = 1'b0;
    step();
    step();
    checkOutput("r_c6_d_valid", 32'(d_valid), 32'h1);
    checkOutput("r_c6_d_rdata", d_rdata, 32'hDEAD_BEEF);
    checkOutput("r_i_rdata_hold", i_rdata, 32'h00A0_0093);
    step();

    $display("[TB] reset mid access");
    applyStimulus(1'b1, 8'h04, 1'b1, 1'b0, 8'h10, 32'h0, 3'b010);
    grantOrder(2, order, first_cyc, last_cyc);
    checkOutput("pre_rst_order", 32'(order[1:0]), 32'h0);
    step();
    checkOutput("pre_rst_m_en", 32'(m_en), 32'h1);
    rst = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0, 3'b000);
    #1;
    checkOutput("rst_mid_m_en", 32'(m_en), 32'h0);
    checkOutput("rst_mid_m_addr", 32'(m_addr), 32'h0);
    checkOutput("rst_mid_busy", 32'(busy), 32'h0);
    checkOutput("rst_mid_d_rdata", d_rdata, 32'h0);
    @(posedge clk);
    #1;
    checkOutput("rst_hold_d_valid", 32'(d_valid), 32'h0);
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      checkOutput("post_rst_d_valid", 32'(d_valid), 32'h0);
      checkOutput("post_rst_busy", 32'(busy), 32'h0);
    end
    applyStimulus(1'b1, 8'h04, 1'b1, 1'b0, 8'h10, 32'h0, 3'b010);
    grantOrder(4, order, first_cyc, last_cyc);
    checkOutput("post_rst_order", 32'(order[3:0]), 32'h1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0, 3'b000);
    repeat (3) step();

    $display("[TB] LATENCY=1 instance");
    x_i_req = 1'b1;
    x_i_addr = 8'h04;
    step();
    checkOutput("l1_c1_i_gnt", 32'(x_i_gnt), 32'h1);
    checkOutput("l1_c1_m_en", 32'(x_m_en), 32'h1);
    x_i_req = 1'b0;
    step();
    checkOutput("l1_c2_i_valid", 32'(x_i_valid), 32'h1);
    checkOutput("l1_c2_i_rdata", x_i_rdata, 32'h00A0_0093);
    checkOutput("l1_c2_m_en", 32'(x_m_en), 32'h0);
    step();
    checkOutput("l1_c3_busy", 32'(x_busy), 32'h0);
    x_d_req = 1'b1;
    x_d_addr = 8'h10;
    cyc = 0;
    cnt = 0;
    first_cyc = -1;
    last_cyc = -1;
    while (cnt < 3 && cyc < 30) begin
      step();
      cyc++;
      if (x_d_gnt) begin
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        cnt++;
      end
    end
    checkOutput("l1_b2b_count", 32'(cnt), 32'd3);
    checkOutput("l1_b2b_spacing", 32'(last_cyc - first_cyc), 32'd4);
    x_d_req = 1'b0;
    repeat (3) step();
    checkOutput("l1_d_rdata", x_d_rdata, 32'h1234_5678);
    checkOutput("l1_drain_busy", 32'(x_busy), 32'h0);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
